// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
package loader_pkg;

  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StFull
  } ld_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw push button, debounces it and emits a one-cycle pulse per accepted press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Accepted level flips only after DEBOUNCE_CYC consecutive cycles at the new level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/imem_loader.sv
// Assembles 32-bit words from button-clocked switch bytes and writes them to IMEM, holding the CPU.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DEBOUNCE_CYC = 250000
) (
  input  logic                SYS_clk,
  input  logic                SYS_rst,
  input  logic                ld_en,
  input  logic                ld_btn,
  input  logic [BYTE_W-1:0]   ld_byte,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_waddr,
  output logic [INSTR_W-1:0]  imem_wdata,
  output logic                cpu_hold,
  output logic [1:0]          byte_idx,
  output logic [ADDR_W:0]     words_loaded,
  output logic                ld_full
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;
  localparam logic [1:0]        LastIdx  = 2'(BYTES_PER_WORD - 1);

  logic                en_s1_q, en_s2_q;
  logic                press;
  ld_state_e           state_q, state_d;
  logic [INSTR_W-1:0]  word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          idx_q, idx_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                full_q, full_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [INSTR_W-1:0]  wdata_q, wdata_d;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk   (SYS_clk),
    .rst_n (SYS_rst),
    .btn   (ld_btn),
    .press (press)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (en_s2_q) begin
          state_d = StCollect;
          word_d  = '0;
          addr_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          full_d  = 1'b0;
        end
      end
      StCollect: begin
        // A press in the same cycle as the enable falling is dropped with the partial word.
        if (!en_s2_q) begin
          state_d = StIdle;
          idx_d   = '0;
        end else if (press) begin
          word_d = {word_q[INSTR_W-BYTE_W-1:0], ld_byte};
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = {word_q[INSTR_W-BYTE_W-1:0], ld_byte};
            state_d = StWrite;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StWrite: begin
        cnt_d = cnt_q + 1'b1;
        if (addr_q == LastAddr) begin
          full_d  = 1'b1;
          state_d = en_s2_q ? StFull : StIdle;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = en_s2_q ? StCollect : StIdle;
        end
      end
      StFull: begin
        if (!en_s2_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge SYS_clk or negedge SYS_rst) begin
    if (!SYS_rst) begin
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
      state_q <= StIdle;
      word_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      en_s1_q <= ld_en;
      en_s2_q <= en_s1_q;
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = (state_q != StIdle);
  assign byte_idx     = idx_q;
  assign words_loaded = cnt_q;
  assign ld_full      = full_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader with a 4-word IMEM and a short debounce window.
module tb_imem_loader;

  localparam int unsigned AW = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_en = 1'b0;
  logic          ld_btn = 1'b0;
  logic [7:0]    ld_byte = 8'h00;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic [1:0]    byte_idx;
  logic [AW:0]   words_loaded;
  logic          ld_full;

  int  n_pass = 0;
  int  n_total = 0;
  int  n_writes = 0;
  int  exp_writes = 0;
  wr_t exp_q[$];

  imem_loader #(
    .ADDR_W       (AW),
    .DEBOUNCE_CYC (4)
  ) dut (
    .SYS_clk      (clk),
    .SYS_rst      (rst_n),
    .ld_en        (ld_en),
    .ld_btn       (ld_btn),
    .ld_byte      (ld_byte),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .byte_idx     (byte_idx),
    .words_loaded (words_loaded),
    .ld_full      (ld_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      wr_t e;
      n_writes++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 imem_waddr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(imem_waddr), 32'(e.addr));
        chk("write_data", imem_wdata, e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] b);
    ld_byte = b;
    ld_btn  = 1'b1;
    tick(12);
    ld_btn  = 1'b0;
    tick(12);
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
    exp_writes++;
    press(d[31:24]);
    press(d[23:16]);
    press(d[15:8]);
    press(d[7:0]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    32'(imem_we),      32'd0);
    chk({tag, "_waddr"}, 32'(imem_waddr),   32'd0);
    chk({tag, "_wdata"}, imem_wdata,        32'd0);
    chk({tag, "_hold"},  32'(cpu_hold),     32'd0);
    chk({tag, "_idx"},   32'(byte_idx),     32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    chk({tag, "_full"},  32'(ld_full),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  initial begin
    tick(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // 1: one clean word
    ld_en = 1'b1;
    tick(4);
    chk("t1_hold_on", 32'(cpu_hold), 32'd1);
    push_word(2'd0, 32'h2008_0005);
    chk("t1_words", 32'(words_loaded), 32'd1);
    chk("t1_idx", 32'(byte_idx), 32'd0);
    chk("t1_hold", 32'(cpu_hold), 32'd1);

    // 2: bouncy press counts once
    ld_byte = 8'hAA;
    ld_btn = 1'b1; tick(1);
    ld_btn = 1'b0; tick(1);
    ld_btn = 1'b1; tick(1);
    tick(10);
    ld_btn = 1'b0;
    tick(12);
    chk("t2_idx", 32'(byte_idx), 32'd1);
    exp_q.push_back('{addr: 2'd1, data: 32'hAA11_2233});
    exp_writes++;
    press(8'h11);
    press(8'h22);
    press(8'h33);
    chk("t2_words", 32'(words_loaded), 32'd2);

    // 3: partial word dropped on disable, restart at address 0
    press(8'h44);
    press(8'h55);
    chk("t3_idx_partial", 32'(byte_idx), 32'd2);
    ld_en = 1'b0;
    tick(5);
    chk("t3_hold_off", 32'(cpu_hold), 32'd0);
    chk("t3_idx_clear", 32'(byte_idx), 32'd0);
    chk("t3_no_write", 32'(n_writes), 32'(exp_writes));
    ld_en = 1'b1;
    tick(5);
    chk("t3_words_clear", 32'(words_loaded), 32'd0);
    push_word(2'd0, 32'h0102_0304);
    chk("t3_words", 32'(words_loaded), 32'd1);

    // 4: fill the 4-word memory, then presses are ignored
    push_word(2'd1, 32'hDEAD_BEEF);
    push_word(2'd2, 32'h1234_5678);
    push_word(2'd3, 32'hCAFE_F00D);
    chk("t4_full", 32'(ld_full), 32'd1);
    chk("t4_words", 32'(words_loaded), 32'd4);
    chk("t4_hold", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 4; i++) press(8'h77);
    chk("t4_idx", 32'(byte_idx), 32'd0);
    chk("t4_no_write", 32'(n_writes), 32'(exp_writes));

    // 5: re-entry clears full; async reset mid-word
    ld_en = 1'b0;
    tick(5);
    ld_en = 1'b1;
    tick(5);
    chk("t5_full_clear", 32'(ld_full), 32'd0);
    press(8'h01);
    press(8'h02);
    press(8'h03);
    chk("t5_idx3", 32'(byte_idx), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    push_word(2'd0, 32'hA1B2_C3D4);
    chk("t5_words", 32'(words_loaded), 32'd1);

    // 6: presses with loader disabled do nothing
    ld_en = 1'b0;
    tick(5);
    press(8'h99);
    press(8'h98);
    chk("t6_hold", 32'(cpu_hold), 32'd0);
    chk("t6_idx", 32'(byte_idx), 32'd0);
    chk("t6_words", 32'(words_loaded), 32'd1);
    chk("t6_no_write", 32'(n_writes), 32'(exp_writes));
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
